// File: rtl/uart_setpoint_parser_if.sv
// Byte stream from the UART receiver into the setpoint parser.
// One byte per rx_valid strobe; there is no back-pressure.
interface uart_setpoint_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );
endinterface

// File: rtl/uart_setpoint_parser.sv
// Decodes ASCII S<n>/H<n> commands from the UART byte stream.
// Holds the setpoint and hysteresis registers read by the control loop.
module uart_setpoint_parser #(
    parameter int SP_DEFAULT   = 25,
    parameter int SP_MIN       = 10,
    parameter int SP_MAX       = 60,
    parameter int HYST_DEFAULT = 2,
    parameter int HYST_MAX     = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_setpoint_parser_if.slave        rx,
    output logic [7:0]                   setpoint,
    output logic [7:0]                   hysteresis,
    output logic                         cmd_update,
    output logic                         cmd_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [9:0] SP_MIN_W = 10'(SP_MIN);
    localparam logic [9:0] SP_MAX_W = 10'(SP_MAX);
    localparam logic [9:0] HY_MAX_W = 10'(HYST_MAX);

    state_t     state, state_d;
    logic       tgt_h, tgt_h_d;
    logic [1:0] cnt, cnt_d;
    logic [9:0] acc, acc_d;
    logic [7:0] sp_d, hy_d;
    logic       upd_d, err_d;

    logic       is_letter, is_h, is_digit, is_term, in_range;
    logic [9:0] acc_x10;

    assign is_h      = (rx.rx_data == 8'h48) || (rx.rx_data == 8'h68);
    assign is_letter = is_h || (rx.rx_data == 8'h53) || (rx.rx_data == 8'h73);
    assign is_digit  = (rx.rx_data >= 8'h30) && (rx.rx_data <= 8'h39);
    assign is_term   = (rx.rx_data == 8'h0D) || (rx.rx_data == 8'h0A);
    assign acc_x10   = (acc << 3) + (acc << 1);

    // Full 10-bit compare so e.g. 999 can never alias into range.
    assign in_range = tgt_h ? (acc <= HY_MAX_W)
                            : ((acc >= SP_MIN_W) && (acc <= SP_MAX_W));

    always_comb begin
        state_d = state;
        tgt_h_d = tgt_h;
        cnt_d   = cnt;
        acc_d   = acc;
        sp_d    = setpoint;
        hy_d    = hysteresis;
        upd_d   = 1'b0;
        err_d   = 1'b0;
        if (rx.rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_letter) begin
                        tgt_h_d = is_h;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = DIGITS;
                    end else if (!is_term) begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DIGITS: begin
                    if (is_digit && cnt != 2'd3) begin
                        acc_d = acc_x10 + {6'd0, rx.rx_data[3:0]};
                        cnt_d = cnt + 2'd1;
                    end else if (is_term) begin
                        state_d = IDLE;
                        if (cnt != 2'd0 && in_range) begin
                            upd_d = 1'b1;
                            if (tgt_h) hy_d = acc[7:0];
                            else       sp_d = acc[7:0];
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (is_term) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tgt_h      <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            setpoint   <= 8'(SP_DEFAULT);
            hysteresis <= 8'(HYST_DEFAULT);
            cmd_update <= 1'b0;
            cmd_error  <= 1'b0;
        end else begin
            state      <= state_d;
            tgt_h      <= tgt_h_d;
            cnt        <= cnt_d;
            acc        <= acc_d;
            setpoint   <= sp_d;
            hysteresis <= hy_d;
            cmd_update <= upd_d;
            cmd_error  <= err_d;
        end
    end

endmodule
